// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: shared widths, FSM states, program start addresses and select encodings
package prog_ctr_pkg;
    localparam int PC_W  = 10;
    localparam int PTR_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_e;

    localparam logic [1:0] SEL_P1   = 2'd0;
    localparam logic [1:0] SEL_P2   = 2'd1;
    localparam logic [1:0] SEL_P3   = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    localparam logic [PC_W-1:0] P1_START = 10'd0;
    localparam logic [PC_W-1:0] P2_START = 10'd320;
    localparam logic [PC_W-1:0] P3_START = 10'd640;

    // The reserved select falls back to program 1.
    function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
        return sel == SEL_P2 ? P2_START : sel == SEL_P3 ? P3_START : P1_START;
    endfunction
endpackage

// File: rtl/prog_ctr_if.sv
// prog_ctr_if: control, branch-table and status signals of the program counter
interface prog_ctr_if #(
    parameter int PC_W  = prog_ctr_pkg::PC_W,
    parameter int PTR_W = prog_ctr_pkg::PTR_W,
    parameter int CNT_W = prog_ctr_pkg::CNT_W
);
    logic             start;
    logic [1:0]       prog_sel;
    logic             halt;
    logic             branch_en;
    logic             zero_flag;
    logic [PTR_W-1:0] lut_idx;
    logic [PTR_W-1:0] lut_pointer;
    logic [PC_W-1:0]  abs_address;
    logic [PC_W-1:0]  prog_ctr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, prog_sel, halt, branch_en, zero_flag, lut_idx, abs_address,
        input  lut_pointer, prog_ctr, busy, done, cycle_count
    );
    modport slave (
        input  start, prog_sel, halt, branch_en, zero_flag, lut_idx, abs_address,
        output lut_pointer, prog_ctr, busy, done, cycle_count
    );
endinterface

// File: rtl/prog_ctr.sv
// prog_ctr: IDLE/RUN/HALTED program counter with table branches and a saturating run-cycle counter
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W  = prog_ctr_pkg::PC_W,
    parameter int PTR_W = prog_ctr_pkg::PTR_W,
    parameter int CNT_W = prog_ctr_pkg::CNT_W
) (
    input logic         clk_i,
    input logic         rst_i,
    prog_ctr_if.slave   bus
);
    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                state_d = bus.halt ? ST_HALTED : ST_RUN;
                // Halt wins over a simultaneous branch and freezes the PC.
                pc_d    = bus.halt ? pc_q :
                          (bus.branch_en && bus.zero_flag) ? bus.abs_address : pc_q + PC_W'(1);
            end
            default: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = PC_W'(start_addr(bus.prog_sel));
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= state_d == ST_RUN;
            done_q  <= state_d == ST_HALTED;
        end
    end

    assign bus.lut_pointer = bus.lut_idx;
    assign bus.prog_ctr    = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: vector table plus a long saturation run, checked through an expected-result queue
module tb_prog_ctr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_ctr_if bus ();
    prog_ctr dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic        rst, start;
        logic [1:0]  sel;
        logic        halt, br, zf;
        logic [3:0]  idx;
        logic [9:0]  abs;
        logic [9:0]  pc;
        logic        busy, done;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [9:0]  pc;
        logic        busy, done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, s, input logic [1:0] sel, input logic h, b, z,
                                input logic [3:0] idx, input logic [9:0] abs, pc,
                                input logic bu, d, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.start = s; v.sel = sel; v.halt = h; v.br = b; v.zf = z;
        v.idx = idx; v.abs = abs; v.pc = pc; v.busy = bu; v.done = d; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        exp_t e;
        rst           = v.rst;
        bus.start     = v.start;
        bus.prog_sel  = v.sel;
        bus.halt      = v.halt;
        bus.branch_en = v.br;
        bus.zero_flag = v.zf;
        bus.lut_idx   = v.idx;
        bus.abs_address = v.abs;
        #1;
        check($sformatf("lut_pointer[%0d]", n), 32'(bus.lut_pointer), 32'(v.idx));
        sb.push_back('{v.pc, v.busy, v.done, v.cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("prog_ctr[%0d]", n), 32'(bus.prog_ctr), 32'(e.pc));
        check($sformatf("busy[%0d]", n), 32'(bus.busy), 32'(e.busy));
        check($sformatf("done[%0d]", n), 32'(bus.done), 32'(e.done));
        check($sformatf("cycle_count[%0d]", n), 32'(bus.cycle_count), 32'(e.cnt));
        check($sformatf("busy_done_excl[%0d]", n), 32'(bus.busy & bus.done), 32'(0));
    endtask

    initial begin
        bus.start = 0; bus.prog_sel = 0; bus.halt = 0; bus.branch_en = 0;
        bus.zero_flag = 0; bus.lut_idx = 0; bus.abs_address = 0;
        //                r  s  sel h  b  z  idx abs    pc  bu d  cnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,     0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0,     320, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,     321, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     322, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     323, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 13,    13,  1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 2, 43,    43,  1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 13,    13,  1, 0, 6));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 43,    14,  1, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 7, 50,    50,  1, 0, 8));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 4, 99,    50,  0, 1, 9));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 4, 7,     50,  0, 1, 9));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0,     640, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0,     0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1023,  1023, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     0,   1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,     1,   1, 0, 4));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0,     0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 9, 77,    0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 15, 0,    0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,     1,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,     1,   0, 1, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,     320, 1, 0, 0));
        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], i);

        // Saturation: 65540 RUN cycles after a start from program 1.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 101);
        bus.start = 0;
        repeat (65539) @(posedge clk);
        #1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 16'hFFFF), 102);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 16'hFFFF), 103);
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 5, 0, 1, 16'hFFFF), 104);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 16'hFFFF), 105);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
